// File: rtl/towerplacer_control.sv
// rtl/towerplacer_control.sv - Moore FSM turning key presses into one-hot tower-placer datapath strobes
module towerplacer_control #(
  parameter int MAX_TOWERS = 8,
  parameter int CNT_W      = 4,
  parameter int TIMEOUT    = 2048
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             key_right,
  input  logic             key_down,
  input  logic             key_place,
  input  logic             square_done,
  input  logic             erase_square_done,
  input  logic             tower_done,
  input  logic             valid,
  output logic             top_left,
  output logic             draw_square,
  output logic             move_right,
  output logic             move_down,
  output logic             move_right_wait,
  output logic             move_down_wait,
  output logic             draw_tower,
  output logic             erase_square_right,
  output logic             erase_square_down,
  output logic             erase_square_tower,
  output logic             busy,
  output logic [CNT_W-1:0] towers_placed,
  output logic             place_refused,
  output logic             fault,
  output logic [3:0]       state_dbg
);

  localparam int DW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [DW-1:0]    DWELL_LAST = DW'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MAX_CNT    = CNT_W'(MAX_TOWERS);

  typedef enum logic [3:0] {
    S_TOP_LEFT    = 4'd0,
    S_DRAW_SQ     = 4'd1,
    S_IDLE        = 4'd2,
    S_ERASE_R     = 4'd3,
    S_MOVE_R      = 4'd4,
    S_MOVE_R_WAIT = 4'd5,
    S_ERASE_D     = 4'd6,
    S_MOVE_D      = 4'd7,
    S_MOVE_D_WAIT = 4'd8,
    S_ERASE_T     = 4'd9,
    S_DRAW_TOWER  = 4'd10
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [CNT_W-1:0] towers_q, towers_d;
  logic             refused_q, refused_d;
  logic             fault_q, fault_d;
  logic [2:0]       key_q;
  logic [2:0]       press;
  logic             wait_st;
  logic             qual;
  state_e           done_state;

  // press bits ordered {place, right, down}
  assign press = {key_place, key_right, key_down} & ~key_q;

  always_comb begin
    state_d    = state_q;
    towers_d   = towers_q;
    refused_d  = 1'b0;
    fault_d    = 1'b0;
    wait_st    = 1'b0;
    qual       = 1'b0;
    done_state = S_TOP_LEFT;
    case (state_q)
      S_TOP_LEFT:    state_d = S_DRAW_SQ;
      S_DRAW_SQ:     begin wait_st = 1'b1; qual = square_done;       done_state = S_IDLE;       end
      S_ERASE_R:     begin wait_st = 1'b1; qual = erase_square_done; done_state = S_MOVE_R;     end
      S_MOVE_R:      begin wait_st = 1'b1; qual = valid;             done_state = S_MOVE_R_WAIT; end
      S_MOVE_R_WAIT: state_d = S_DRAW_SQ;
      S_ERASE_D:     begin wait_st = 1'b1; qual = erase_square_done; done_state = S_MOVE_D;     end
      S_MOVE_D:      begin wait_st = 1'b1; qual = valid;             done_state = S_MOVE_D_WAIT; end
      S_MOVE_D_WAIT: state_d = S_DRAW_SQ;
      S_ERASE_T:     begin wait_st = 1'b1; qual = erase_square_done; done_state = S_DRAW_TOWER; end
      S_DRAW_TOWER:  begin wait_st = 1'b1; qual = tower_done;        done_state = S_TOP_LEFT;   end
      S_IDLE: begin
        if (press[2]) begin
          if (towers_q == MAX_CNT) refused_d = 1'b1;
          else                     state_d   = S_ERASE_T;
        end else if (press[1]) begin
          state_d = S_ERASE_R;
        end else if (press[0]) begin
          state_d = S_ERASE_D;
        end
      end
      default: state_d = S_TOP_LEFT;
    endcase

    // First dwell cycle masks feedback: the datapath's done flags are registered and may be stale
    if (wait_st) begin
      if (qual && dwell_q != '0) begin
        state_d = done_state;
        if (state_q == S_DRAW_TOWER && towers_q != MAX_CNT) towers_d = towers_q + CNT_W'(1);
      end else if (dwell_q == DWELL_LAST) begin
        state_d = S_TOP_LEFT;
        fault_d = 1'b1;
      end
    end

    if (state_d != state_q)        dwell_d = '0;
    else if (dwell_q == DWELL_LAST) dwell_d = dwell_q;
    else                            dwell_d = dwell_q + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_TOP_LEFT;
      dwell_q   <= '0;
      towers_q  <= '0;
      refused_q <= 1'b0;
      fault_q   <= 1'b0;
      key_q     <= 3'b111;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      towers_q  <= towers_d;
      refused_q <= refused_d;
      fault_q   <= fault_d;
      key_q     <= {key_place, key_right, key_down};
    end
  end

  assign top_left           = (state_q == S_TOP_LEFT);
  assign draw_square        = (state_q == S_DRAW_SQ);
  assign erase_square_right = (state_q == S_ERASE_R);
  assign move_right         = (state_q == S_MOVE_R);
  assign move_right_wait    = (state_q == S_MOVE_R_WAIT);
  assign erase_square_down  = (state_q == S_ERASE_D);
  assign move_down          = (state_q == S_MOVE_D);
  assign move_down_wait     = (state_q == S_MOVE_D_WAIT);
  assign erase_square_tower = (state_q == S_ERASE_T);
  assign draw_tower         = (state_q == S_DRAW_TOWER);
  assign busy               = (state_q != S_IDLE);
  assign towers_placed      = towers_q;
  assign place_refused      = refused_q;
  assign fault              = fault_q;
  assign state_dbg          = state_q;

endmodule

// File: tb/tb_towerplacer_control.sv
// tb/tb_towerplacer_control.sv - directed self-checking bench for towerplacer_control
module tb_towerplacer_control;

  logic       clk, resetn;
  logic       key_right, key_down, key_place;
  logic       square_done, erase_square_done, tower_done, valid;
  logic       top_left, draw_square, move_right, move_down, move_right_wait, move_down_wait;
  logic       draw_tower, erase_square_right, erase_square_down, erase_square_tower;
  logic       busy, place_refused, fault;
  logic [3:0] towers_placed;
  logic [3:0] state_dbg;
  logic [9:0] strb;
  int         chk_cnt = 0;
  int         pass_cnt = 0;

  towerplacer_control #(.MAX_TOWERS(8), .CNT_W(4), .TIMEOUT(2048)) dut (
    .clk(clk), .resetn(resetn),
    .key_right(key_right), .key_down(key_down), .key_place(key_place),
    .square_done(square_done), .erase_square_done(erase_square_done),
    .tower_done(tower_done), .valid(valid),
    .top_left(top_left), .draw_square(draw_square), .move_right(move_right),
    .move_down(move_down), .move_right_wait(move_right_wait), .move_down_wait(move_down_wait),
    .draw_tower(draw_tower), .erase_square_right(erase_square_right),
    .erase_square_down(erase_square_down), .erase_square_tower(erase_square_tower),
    .busy(busy), .towers_placed(towers_placed), .place_refused(place_refused),
    .fault(fault), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign strb = {top_left, draw_square, move_right, move_down, move_right_wait, move_down_wait,
                 draw_tower, erase_square_right, erase_square_down, erase_square_tower};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    tick(); tick();
    square_done = 1'b1; tick(); square_done = 1'b0;
  endtask

  task automatic place_tower();
    key_place = 1'b1; tick(); key_place = 1'b0;
    tick(); erase_square_done = 1'b1; tick(); erase_square_done = 1'b0;
    tick(); tower_done = 1'b1; tick(); tower_done = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; key_right = 1'b1;
    tick(); tick();
    chk_cnt++; if (state_dbg !== 4'd0) $display("FAIL reset_state got=%0d exp=0", state_dbg); else pass_cnt++;
    chk_cnt++; if (top_left !== 1'b1 || busy !== 1'b1) $display("FAIL reset_top_left got=%b/%b exp=1/1", top_left, busy); else pass_cnt++;
    chk_cnt++; if (towers_placed !== 4'd0 || fault !== 1'b0 || place_refused !== 1'b0) $display("FAIL reset_regs got=%0d/%b/%b exp=0/0/0", towers_placed, fault, place_refused); else pass_cnt++;
    resetn = 1'b1; tick();
    chk_cnt++; if (state_dbg !== 4'd1 || strb !== 10'b0100000000) $display("FAIL reset_drawsq got=%0d/%b exp=1/0100000000", state_dbg, strb); else pass_cnt++;
    tick(); tick(); square_done = 1'b1; tick(); square_done = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd2 || busy !== 1'b0 || strb !== 10'b0) $display("FAIL reset_idle got=%0d/%b/%b exp=2/0/0", state_dbg, busy, strb); else pass_cnt++;
    repeat (3) tick();
    chk_cnt++; if (state_dbg !== 4'd2) $display("FAIL held_key_no_press got=%0d exp=2", state_dbg); else pass_cnt++;
  endtask

  task automatic test_right_move();
    key_right = 1'b0; tick(); key_right = 1'b1; tick(); key_right = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd3 || strb !== 10'b0000000100) $display("FAIL right_erase got=%0d/%b exp=3/0000000100", state_dbg, strb); else pass_cnt++;
    tick(); tick();
    chk_cnt++; if (state_dbg !== 4'd3) $display("FAIL right_erase_hold got=%0d exp=3", state_dbg); else pass_cnt++;
    erase_square_done = 1'b1; tick(); erase_square_done = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd4 || strb !== 10'b0010000000) $display("FAIL right_move got=%0d/%b exp=4/0010000000", state_dbg, strb); else pass_cnt++;
    tick(); valid = 1'b1; tick(); valid = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd5 || strb !== 10'b0000100000) $display("FAIL right_wait got=%0d/%b exp=5/0000100000", state_dbg, strb); else pass_cnt++;
    tick();
    chk_cnt++; if (state_dbg !== 4'd1 || $countones(strb) !== 1 || draw_square !== 1'b1) $display("FAIL right_drawsq got=%0d/%b exp=1/0100000000", state_dbg, strb); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_place_priority();
    key_place = 1'b1; key_down = 1'b1; tick(); key_place = 1'b0; key_down = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd9 || strb !== 10'b0000000001) $display("FAIL prio_erase_t got=%0d/%b exp=9/0000000001", state_dbg, strb); else pass_cnt++;
    tick(); erase_square_done = 1'b1; tick(); erase_square_done = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd10 || draw_tower !== 1'b1 || towers_placed !== 4'd0) $display("FAIL prio_draw_tower got=%0d/%b/%0d exp=10/1/0", state_dbg, draw_tower, towers_placed); else pass_cnt++;
    tick(); tower_done = 1'b1; tick(); tower_done = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd0 || towers_placed !== 4'd1) $display("FAIL prio_tower_count got=%0d/%0d exp=0/1", state_dbg, towers_placed); else pass_cnt++;
    go_idle();
  endtask

  task automatic test_budget();
    for (int i = 0; i < 7; i++) begin
      place_tower();
      go_idle();
    end
    chk_cnt++; if (towers_placed !== 4'd8 || state_dbg !== 4'd2) $display("FAIL budget_full got=%0d/%0d exp=8/2", towers_placed, state_dbg); else pass_cnt++;
    key_place = 1'b1; tick(); key_place = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd2 || place_refused !== 1'b1) $display("FAIL budget_refused got=%0d/%b exp=2/1", state_dbg, place_refused); else pass_cnt++;
    tick();
    chk_cnt++; if (place_refused !== 1'b0 || towers_placed !== 4'd8 || state_dbg !== 4'd2) $display("FAIL budget_pulse_end got=%b/%0d/%0d exp=0/8/2", place_refused, towers_placed, state_dbg); else pass_cnt++;
  endtask

  task automatic test_watchdog();
    key_right = 1'b1; tick(); key_right = 1'b0;
    tick(); erase_square_done = 1'b1; tick(); erase_square_done = 1'b0;
    tick(); valid = 1'b1; tick(); valid = 1'b0;
    tick();
    chk_cnt++; if (state_dbg !== 4'd1) $display("FAIL wd_enter got=%0d exp=1", state_dbg); else pass_cnt++;
    square_done = 1'b1; tick(); square_done = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd1 || fault !== 1'b0) $display("FAIL stale_done_ignored got=%0d/%b exp=1/0", state_dbg, fault); else pass_cnt++;
    repeat (2046) tick();
    chk_cnt++; if (state_dbg !== 4'd1 || fault !== 1'b0) $display("FAIL wd_early got=%0d/%b exp=1/0", state_dbg, fault); else pass_cnt++;
    tick();
    chk_cnt++; if (state_dbg !== 4'd0 || fault !== 1'b1 || top_left !== 1'b1) $display("FAIL wd_fire got=%0d/%b/%b exp=0/1/1", state_dbg, fault, top_left); else pass_cnt++;
    chk_cnt++; if (towers_placed !== 4'd8) $display("FAIL wd_towers got=%0d exp=8", towers_placed); else pass_cnt++;
    tick();
    chk_cnt++; if (fault !== 1'b0 || state_dbg !== 4'd1) $display("FAIL wd_pulse_end got=%b/%0d exp=0/1", fault, state_dbg); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tick(); square_done = 1'b1; tick(); square_done = 1'b0;
    key_down = 1'b1; tick(); key_down = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd6 || strb !== 10'b0000000010) $display("FAIL down_erase got=%0d/%b exp=6/0000000010", state_dbg, strb); else pass_cnt++;
    tick(); erase_square_done = 1'b1; tick(); erase_square_done = 1'b0;
    chk_cnt++; if (state_dbg !== 4'd7 || strb !== 10'b0001000000) $display("FAIL down_move got=%0d/%b exp=7/0001000000", state_dbg, strb); else pass_cnt++;
    valid = 1'b1; resetn = 1'b0; tick(); valid = 1'b0; resetn = 1'b1;
    chk_cnt++; if (state_dbg !== 4'd0 || strb !== 10'b1000000000) $display("FAIL midreset_state got=%0d/%b exp=0/1000000000", state_dbg, strb); else pass_cnt++;
    chk_cnt++; if (towers_placed !== 4'd0) $display("FAIL midreset_towers got=%0d exp=0", towers_placed); else pass_cnt++;
    tick();
    chk_cnt++; if (state_dbg !== 4'd1) $display("FAIL midreset_resume got=%0d exp=1", state_dbg); else pass_cnt++;
  endtask

  initial begin
    resetn = 1'b0; key_right = 1'b0; key_down = 1'b0; key_place = 1'b0;
    square_done = 1'b0; erase_square_done = 1'b0; tower_done = 1'b0; valid = 1'b0;
    test_reset();
    test_right_move();
    test_place_priority();
    test_budget();
    test_watchdog();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
